bit_stream_source: RTL and testbench

//  Serial bit-stream source feeding the sequence-detector path. Reads packed words from Block RAM
//  and shifts them out MSB-first, one bit per one_second_enable tick, for a programmed length.

---
 rtl/bit_stream_source_pkg.sv | 16 +
 rtl/bit_stream_source_word_prefetch.sv | 32 +++
 rtl/bit_stream_source.sv | 155 +++++++++++++++
 tb/tb_bit_stream_source.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_stream_source_pkg.sv
// Shared constants for the serial bit-stream source and its downstream pattern detector.
package bit_stream_source_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_PRIME = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/bit_stream_source_word_prefetch.sv
// One-word prefetch buffer with a full flag; load fills it, take marks it empty.
module word_prefetch #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              take_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o
);

  logic [WORD_W-1:0] data_q;
  logic              full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= load_data_i;
      full_q <= 1'b1;
    end else if (take_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/bit_stream_source.sv
// Streams BRAM words out MSB-first, one bit per rate tick, with a one-word prefetch so
// word boundaries never stall.
module bit_stream_source
  import bit_stream_source_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              one_second_enable,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_bits,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WORD_W-1:0] ram_data,
  output logic              serial_bit,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  bits_left_q, bits_left_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ram_en_q, ram_en_d;
  logic              data_vld_q;
  logic              serial_q, serial_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pf_load, pf_take, pf_full;
  logic [WORD_W-1:0] pf_data;

  // Read data lands one clock after ram_en; in PRIME it is word 0, later reads refill the prefetch.
  assign pf_load = data_vld_q && (state_q == ST_RUN);

  word_prefetch #(.WORD_W(WORD_W)) u_prefetch (
    .clk_i       (clock_100Mhz),
    .rst_i       (reset),
    .load_i      (pf_load),
    .load_data_i (ram_data),
    .take_i      (pf_take),
    .data_o      (pf_data),
    .full_o      (pf_full)
  );

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    ram_en_d    = 1'b0;
    serial_d    = serial_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pf_take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_bits != '0) begin
            bits_left_d = num_bits;
            bit_idx_d   = '0;
            addr_d      = '0;
            ram_en_d    = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        addr_d   = addr_q + ADDR_W'(1);
        ram_en_d = 1'b1;
        state_d  = ST_PRIME;
      end
      ST_PRIME: begin
        shift_d = ram_data;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (one_second_enable) begin
          serial_d    = shift_q[WORD_W-1];
          valid_d     = 1'b1;
          bits_left_d = bits_left_q - LEN_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            shift_d   = pf_data;
            pf_take   = pf_full;
            bit_idx_d = '0;
            if (bits_left_q != LEN_W'(1)) begin
              addr_d   = addr_q + ADDR_W'(1);
              ram_en_d = 1'b1;
            end
          end else begin
            shift_d   = {shift_q[WORD_W-2:0], 1'b0};
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
          if (bits_left_q == LEN_W'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      ram_en_q    <= 1'b0;
      data_vld_q  <= 1'b0;
      serial_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      ram_en_q    <= ram_en_d;
      data_vld_q  <= ram_en_q;
      serial_q    <= serial_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = addr_q;
  assign serial_bit = serial_q;
  assign bit_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bit_stream_source.sv
// Directed bench: two sources (10-bit and 2-bit address) fed by behavioural BRAMs.
module tb_bit_stream_source;
  import bit_stream_source_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;

  logic        a_start = 1'b0;
  logic [15:0] a_num = '0;
  logic        a_ram_en;
  logic [9:0]  a_ram_addr;
  logic [7:0]  a_ram_data = '0;
  logic        a_serial, a_valid, a_busy, a_done;

  logic        b_start = 1'b0;
  logic [15:0] b_num = '0;
  logic        b_ram_en;
  logic [1:0]  b_ram_addr;
  logic [7:0]  b_ram_data = '0;
  logic        b_serial, b_valid, b_busy, b_done;

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [4];

  bit         a_bits[$];
  logic [9:0] a_addrs[$];
  int         a_done_cnt = 0;
  int         a_busy_cyc = 0;
  bit         b_bits[$];
  logic [1:0] b_addrs[$];
  int         b_done_cnt = 0;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  bit_stream_source #(.WORD_W(8), .ADDR_W(10), .LEN_W(16)) dut_a (
    .clock_100Mhz      (clk),
    .reset             (rst),
    .one_second_enable (tick),
    .start             (a_start),
    .num_bits          (a_num),
    .ram_en            (a_ram_en),
    .ram_addr          (a_ram_addr),
    .ram_data          (a_ram_data),
    .serial_bit        (a_serial),
    .bit_valid         (a_valid),
    .busy              (a_busy),
    .done              (a_done)
  );

  bit_stream_source #(.WORD_W(8), .ADDR_W(2), .LEN_W(16)) dut_b (
    .clock_100Mhz      (clk),
    .reset             (rst),
    .one_second_enable (tick),
    .start             (b_start),
    .num_bits          (b_num),
    .ram_en            (b_ram_en),
    .ram_addr          (b_ram_addr),
    .ram_data          (b_ram_data),
    .serial_bit        (b_serial),
    .bit_valid         (b_valid),
    .busy              (b_busy),
    .done              (b_done)
  );

  always @(posedge clk) begin
    if (a_ram_en) a_ram_data <= mem_a[a_ram_addr];
    if (b_ram_en) b_ram_data <= mem_b[b_ram_addr];
  end

  always @(negedge clk) begin
    if (a_valid)  a_bits.push_back(a_serial);
    if (a_ram_en) a_addrs.push_back(a_ram_addr);
    if (a_done)   a_done_cnt++;
    if (a_busy)   a_busy_cyc++;
    if (b_valid)  b_bits.push_back(b_serial);
    if (b_ram_en) b_addrs.push_back(b_ram_addr);
    if (b_done)   b_done_cnt++;
  end

  function automatic logic [63:0] pack_bits(input bit q[$], input int from, input int n);
    logic [63:0] v = '0;
    for (int i = from; i < from + n; i++) v = {v[62:0], q[i]};
    return v;
  endfunction

  function automatic int count_pattern(input bit q[$], input int from, input int n);
    logic [3:0] hist = '0;
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      hist = {hist[2:0], q[from + i]};
      if (i >= 3 && hist == PATTERN) cnt++;
    end
    return cnt;
  endfunction

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic start_a(input logic [15:0] n);
    a_start = 1'b1;
    a_num   = n;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vec_cnt++;
    if ({a_serial, a_valid, a_busy, a_done, a_ram_en} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected 00000", {a_serial, a_valid, a_busy, a_done, a_ram_en});
    end
    vec_cnt++;
    if (a_ram_addr !== 10'd0) begin
      err_cnt++;
      $display("FAIL reset_addr: got %0d expected 0", a_ram_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_word;
    int b0 = a_bits.size();
    int d0 = a_done_cnt;
    int r0 = a_addrs.size();
    mem_a[0] = 8'hB2;
    mem_a[1] = 8'h77;
    start_a(16'd8);
    vec_cnt++;
    if (a_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_busy: got %b expected 1", a_busy);
    end
    // This tick lands while the source is still filling and must not emit a bit.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse_ticks(8);
    vec_cnt++;
    if (a_bits.size() - b0 !== 8) begin
      err_cnt++;
      $display("FAIL single_count: got %0d expected 8", a_bits.size() - b0);
    end
    vec_cnt++;
    if (pack_bits(a_bits, b0, 8) !== 64'hB2) begin
      err_cnt++;
      $display("FAIL single_bits: got %h expected b2", pack_bits(a_bits, b0, 8));
    end
    vec_cnt++;
    if (a_done_cnt - d0 !== 1) begin
      err_cnt++;
      $display("FAIL single_done: got %0d expected 1", a_done_cnt - d0);
    end
    vec_cnt++;
    if (a_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_busy_end: got %b expected 0", a_busy);
    end
    vec_cnt++;
    if (a_addrs[r0] !== 10'd0) begin
      err_cnt++;
      $display("FAIL single_first_addr: got %0d expected 0", a_addrs[r0]);
    end
  endtask

  task automatic test_three_words;
    int b0 = a_bits.size();
    int r0 = a_addrs.size();
    mem_a[0] = 8'hFF;
    mem_a[1] = 8'h00;
    mem_a[2] = 8'hA5;
    start_a(16'd24);
    repeat (2) @(posedge clk);
    #1;
    pulse_ticks(24);
    vec_cnt++;
    if (pack_bits(a_bits, b0, 24) !== 64'hFF00A5 || a_bits.size() - b0 !== 24) begin
      err_cnt++;
      $display("FAIL three_bits: got %h (%0d bits) expected ff00a5 (24 bits)", pack_bits(a_bits, b0, 24), a_bits.size() - b0);
    end
    vec_cnt++;
    if (a_addrs.size() - r0 < 3 || a_addrs.size() - r0 > 4) begin
      err_cnt++;
      $display("FAIL three_reads: got %0d expected 3..4", a_addrs.size() - r0);
    end
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (a_addrs.size() <= r0 + i || a_addrs[r0 + i] !== 10'(i)) begin
        err_cnt++;
        $display("FAIL three_addr%0d: got %0d expected %0d", i, (a_addrs.size() > r0 + i) ? a_addrs[r0 + i] : 10'h3ff, i);
      end
    end
  endtask

  task automatic test_zero_length;
    int d0 = a_done_cnt;
    int c0 = a_busy_cyc;
    int r0 = a_addrs.size();
    int b0 = a_bits.size();
    start_a(16'd0);
    vec_cnt++;
    if (a_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_done_now: got %b expected 1", a_done);
    end
    pulse_ticks(2);
    vec_cnt++;
    if (a_done_cnt - d0 !== 1 || a_busy_cyc - c0 !== 0) begin
      err_cnt++;
      $display("FAIL zero_done_busy: got done=%0d busy_cyc=%0d expected 1 0", a_done_cnt - d0, a_busy_cyc - c0);
    end
    vec_cnt++;
    if (a_addrs.size() - r0 !== 0 || a_bits.size() - b0 !== 0) begin
      err_cnt++;
      $display("FAIL zero_activity: got reads=%0d bits=%0d expected 0 0", a_addrs.size() - r0, a_bits.size() - b0);
    end
  endtask

  task automatic test_partial_and_busy_start;
    int b0 = a_bits.size();
    int d0 = a_done_cnt;
    mem_a[0] = 8'h3C;
    mem_a[1] = 8'h9A;
    start_a(16'd12);
    repeat (2) @(posedge clk);
    #1;
    pulse_ticks(3);
    start_a(16'd5);
    pulse_ticks(9);
    vec_cnt++;
    if (pack_bits(a_bits, b0, 12) !== 64'h3C9 || a_bits.size() - b0 !== 12) begin
      err_cnt++;
      $display("FAIL partial_bits: got %h (%0d bits) expected 3c9 (12 bits)", pack_bits(a_bits, b0, 12), a_bits.size() - b0);
    end
    pulse_ticks(3);
    vec_cnt++;
    if (a_bits.size() - b0 !== 12 || a_done_cnt - d0 !== 1) begin
      err_cnt++;
      $display("FAIL partial_after: got bits=%0d done=%0d expected 12 1", a_bits.size() - b0, a_done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = a_done_cnt;
    int b0;
    int r0;
    mem_a[0] = 8'hB8;
    mem_a[1] = 8'h55;
    start_a(16'd16);
    repeat (2) @(posedge clk);
    #1;
    pulse_ticks(5);
    vec_cnt++;
    if ({a_busy, a_serial} !== 2'b11) begin
      err_cnt++;
      $display("FAIL mid_pre_reset: got busy,bit=%b expected 11", {a_busy, a_serial});
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({a_serial, a_valid, a_busy, a_done, a_ram_en} !== 5'b0 || a_ram_addr !== 10'd0) begin
      err_cnt++;
      $display("FAIL mid_reset_outputs: got %b addr=%0d expected 00000 addr=0", {a_serial, a_valid, a_busy, a_done, a_ram_en}, a_ram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (a_done_cnt - d0 !== 0) begin
      err_cnt++;
      $display("FAIL mid_no_done: got %0d expected 0", a_done_cnt - d0);
    end
    b0 = a_bits.size();
    r0 = a_addrs.size();
    start_a(16'd8);
    repeat (2) @(posedge clk);
    #1;
    pulse_ticks(8);
    vec_cnt++;
    if (pack_bits(a_bits, b0, 8) !== 64'hB8 || a_bits.size() - b0 !== 8 || a_addrs[r0] !== 10'd0) begin
      err_cnt++;
      $display("FAIL mid_restart: got %h (%0d bits) addr0=%0d expected b8 (8 bits) addr0=0", pack_bits(a_bits, b0, 8), a_bits.size() - b0, a_addrs[r0]);
    end
  endtask

  task automatic test_wrap_detector;
    logic [1:0] exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int b0 = b_bits.size();
    int r0 = b_addrs.size();
    int d0 = b_done_cnt;
    mem_b[0] = 8'hB0;
    mem_b[1] = 8'h00;
    mem_b[2] = 8'h00;
    mem_b[3] = 8'h05;
    b_start = 1'b1;
    b_num   = 16'd40;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pulse_ticks(40);
    vec_cnt++;
    if (pack_bits(b_bits, b0, 40) !== 64'hB0_00_00_05_B0 || b_bits.size() - b0 !== 40) begin
      err_cnt++;
      $display("FAIL wrap_bits: got %h (%0d bits) expected b0000005b0 (40 bits)", pack_bits(b_bits, b0, 40), b_bits.size() - b0);
    end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (b_addrs.size() <= r0 + i || b_addrs[r0 + i] !== exp_addr[i]) begin
        err_cnt++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", i, (b_addrs.size() > r0 + i) ? b_addrs[r0 + i] : 2'd0, exp_addr[i]);
      end
    end
    vec_cnt++;
    if (b_bits.size() - b0 < 40 || count_pattern(b_bits, b0, 40) !== 3) begin
      err_cnt++;
      $display("FAIL wrap_detect: got %0d expected 3", (b_bits.size() - b0 >= 40) ? count_pattern(b_bits, b0, 40) : -1);
    end
    vec_cnt++;
    if (b_done_cnt - d0 !== 1 || b_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL wrap_done: got done=%0d busy=%b expected 1 0", b_done_cnt - d0, b_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'h00;
    test_reset();
    test_single_word();
    test_three_words();
    test_zero_length();
    test_partial_and_busy_start();
    test_reset_mid();
    test_wrap_detector();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
